// File: rtl/mdu_seq.sv
// mdu_seq: iterative radix-2 multiply/divide sequencer (RISC-V M ops, ARM MUL).
// Multiply uses shift-add and divide uses restoring subtraction, one bit per cycle.
// Operands are converted to magnitudes on entry, and the sign is fixed up in FIX.
// Optional macro MDU_EARLY_OUT_EN: trivial operations jump from IDLE straight to FIX.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;      // product, or remainder:quotient
    logic [XLEN-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [XLEN-1:0]   a_q, a_d;          // original dividend for divide-by-zero
    logic              sign_a_q, sign_a_d;
    logic              neg_q, neg_d;      // operand signs differ
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand sign handling at accept time
    logic            signed_a, signed_b, sa, sb, accept, early_out;
    logic [XLEN-1:0] mag_a, mag_b;

    assign signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa       = signed_a & a[XLEN-1];
    assign sb       = signed_b & b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    assign accept   = (state_q == S_IDLE) && start && !flush;

`ifdef MDU_EARLY_OUT_EN
    logic div_ovf;
    assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign early_out = op[2] ? ((b == '0) || div_ovf) : ((a == '0) || (b == '0));
`else
    assign early_out = 1'b0;
`endif

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; flush overrides everything, including a start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = early_out ? S_FIX : S_CALC;
            S_CALC: if (count_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

    // Iteration datapath and final sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        result_d = result_q;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        if (accept) begin
            op_d     = op;
            a_d      = a;
            sign_a_d = sa;
            neg_d    = sa ^ sb;
            div0_d   = op[2] && (b == '0);
            count_d  = CW'(XLEN);
            opnd_d   = op[2] ? mag_b : mag_a;
            acc_d    = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            // An early-out multiply has a zero operand, so the product is zero.
            // Early-out overflow already holds the answer (quotient 2^(XLEN-1), remainder 0).
            if (early_out && !op[2]) acc_d = '0;
        end else if (state_q == S_CALC) begin
            count_d = count_q - CW'(1);
            if (!op_q[2]) begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end else if (!div_trial[XLEN+1]) begin
                acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else if ((state_q == S_FIX) && !flush) begin
            case (op_q)
                OP_MUL:                       result_d = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              result_d = div0_q ? '1 : quo_fix;
                OP_REM, OP_REMU:              result_d = div0_q ? a_q : rem_fix;
                default:                      result_d = result_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
// Cycle k means the sample taken at the falling edge after the k-th rising edge,
// where edge 1 is the edge that samples start.
module tb_mdu_seq;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int LAT = 34;
`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    // Runs one operation to completion and reports the result, done cycle, done count and busy length
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int dcyc, output int ndone, output int blen);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; ndone = 0; dcyc = -1; blen = 0;
        while (busy && cyc < 100) begin
            if (done) begin
                ndone++;
                dcyc = cyc;
            end
            blen++;
            @(negedge clk);
            cyc++;
        end
        res = result;
        $display("op=%0d a=%h b=%h result=%h done_cycle=%0d busy_cycles=%0d", o, x, y, res, dcyc, blen);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r; int dc, nd, bl;
        do_op(MUL, 32'd7, 32'hFFFFFFFD, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        checks++; if (dc !== LAT) begin failures++; $display("FAIL mul_done_cycle got=%0d exp=%0d", dc, LAT); end
        checks++; if (bl !== LAT) begin failures++; $display("FAIL mul_busy_len got=%0d exp=%0d", bl, LAT); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL mul_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int dc, nd, bl;
        do_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
        do_op(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, r, dc, nd, bl);
        checks++; if (r !== 32'h00000000) begin failures++; $display("FAIL mulh got=%h exp=00000000", r); end
        do_op(MULHSU, 32'hFFFFFFFF, 32'd2, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int dc, nd, bl;
        do_op(DIV, 32'hFFFFFFF9, 32'd2, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        checks++; if (dc !== LAT) begin failures++; $display("FAIL div_done_cycle got=%0d exp=%0d", dc, LAT); end
        do_op(REM, 32'hFFFFFFF9, 32'd2, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        do_op(DIVU, 32'd100, 32'd7, r, dc, nd, bl);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=0000000e", r); end
        do_op(REMU, 32'd100, 32'd7, r, dc, nd, bl);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=00000002", r); end
    endtask

    task automatic test_div_special();
        logic [31:0] r; int dc, nd, bl;
        do_op(DIVU, 32'h12345678, 32'h0, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
        checks++; if (dc !== LAT_SP) begin failures++; $display("FAIL divu_by0_latency got=%0d exp=%0d", dc, LAT_SP); end
        do_op(REM, 32'hFFFFFFF9, 32'h0, r, dc, nd, bl);
        checks++; if (r !== 32'hFFFFFFF9) begin failures++; $display("FAIL rem_by0 got=%h exp=fffffff9", r); end
        checks++; if (dc !== LAT_SP) begin failures++; $display("FAIL rem_by0_latency got=%0d exp=%0d", dc, LAT_SP); end
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, r, dc, nd, bl);
        checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        checks++; if (dc !== LAT_SP) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=%0d", dc, LAT_SP); end
        do_op(REM, 32'h80000000, 32'hFFFFFFFF, r, dc, nd, bl);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
        checks++; if (dc !== LAT_SP) begin failures++; $display("FAIL rem_ovf_latency got=%0d exp=%0d", dc, LAT_SP); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int dc, nd, bl, cyc, nd2;
        do_op(DIVU, 32'd100, 32'd7, r, dc, nd, bl);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL flush_prior got=%h exp=0000000e", r); end
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nd2 = 0;
        while (cyc < 10) begin
            if (done) nd2++;
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) nd2++;
        $display("flush at cycle 10: busy=%b result=%h done_seen=%0d", busy, result, nd2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (nd2 !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", nd2); end
        checks++; if (result !== 32'd14) begin failures++; $display("FAIL flush_result_held got=%h exp=0000000e", result); end
        do_op(DIV, 32'd1000, 32'd3, r, dc, nd, bl);
        checks++; if (r !== 32'd333) begin failures++; $display("FAIL after_flush got=%h exp=0000014d", r); end
        checks++; if (dc !== LAT) begin failures++; $display("FAIL after_flush_latency got=%0d exp=%0d", dc, LAT); end
        // flush together with start in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        $display("flush+start in idle: busy=%b", busy);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_start_ignored();
        int cyc, nd, late_busy;
        @(negedge clk);
        start = 1'b1; op = MUL; a = 32'd6; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nd = 0;
        while (busy && cyc < 100) begin
            start = 1'b0;
            if (cyc == 5) begin start = 1'b1; a = 32'd100; b = 32'd100; end
            if (done) begin nd++; start = 1'b1; a = 32'd3; b = 32'd3; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        late_busy = 0;
        repeat (4) begin
            if (busy || done) late_busy++;
            @(negedge clk);
        end
        $display("start while busy: result=%h done_count=%0d late_busy=%0d", result, nd, late_busy);
        checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
        checks++; if (result !== 32'd42) begin failures++; $display("FAIL ignore_result got=%h exp=0000002a", result); end
        checks++; if (late_busy !== 0) begin failures++; $display("FAIL ignore_no_restart got=%0d exp=0", late_busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int dc, nd, bl, cyc, nd2;
        @(negedge clk);
        start = 1'b1; op = MUL; a = 32'd7; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nd2 = 0;
        while (cyc < 20) begin
            if (done) nd2++;
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        $display("reset at cycle 20: busy=%b done=%b result=%h", busy, done, result);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0 || nd2 !== 0) begin failures++; $display("FAIL rst_mid_done got=%b/%0d exp=0/0", done, nd2); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result); end
        reset_n = 1'b1;
        @(negedge clk);
        do_op(DIVU, 32'd100, 32'd7, r, dc, nd, bl);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL after_reset got=%h exp=0000000e", r); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
